idli_sqi_mem_v2_m: RTL and testbench

Parametrised behavioural model of an SQI serial SRAM (23LC/25LC-class) for simulation and FPGA test benches, attached to the core's SQI bus in place of a real device. Clocked directly by SCK. Supports READ, WRITE, read mode register (RDMR) and write mode register (WRMR), with byte, page and sequential access modes. Adds configurable address width, dummy-cycle count and page size, an output-enable, and an asynchronous reset.

---
 rtl/idli_sqi_mem_v2_m.sv | 190 +++++++++++++++++++
 tb/tb_idli_sqi_mem_v2_m.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_sqi_mem_v2_m.sv
// Behavioural SQI serial SRAM model (23LC/25LC class) clocked directly by SCK.
// Supports READ, WRITE, RDMR and WRMR with byte, page and sequential modes.
module idli_sqi_mem_v2_m #(
  parameter int SIZE         = 64 * 1024,
  parameter int ADDR_NIBBLES = 4,
  parameter int DUMMY_CYCLES = 2,
  parameter int PAGE_SIZE    = 32
) (
  input  logic       i_sqi_sck,
  input  logic       i_rst,
  input  logic       i_sqi_cs,
  input  logic [3:0] i_sqi_sio,
  output logic [3:0] o_sqi_sio,
  output logic       o_sqi_oe
);

  localparam int ADDR_W = $clog2(SIZE);
  localparam logic [ADDR_W-1:0] PAGE_MASK  = ADDR_W'(PAGE_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [7:0]        ADDR_LAST  = 8'(ADDR_NIBBLES - 1);
  localparam logic [7:0]        DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  localparam logic [7:0] OP_WRMR  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDMR  = 8'h05;

  localparam logic [1:0] MODE_SEQ  = 2'b01;
  localparam logic [1:0] MODE_PAGE = 2'b10;

  typedef enum logic [2:0] {
    ST_INSTR_0, ST_INSTR_1, ST_ADDR, ST_DUMMY, ST_DATA_0, ST_DATA_1, ST_IGNORE
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [3:0]        nib_q, nib_d;
  logic [1:0]        mode_q, mode_d;
  logic              mem_we_s;
  logic [7:0]        mem_wdata_s;
  logic [7:0]        opcode_s;
  logic [7:0]        rd_byte_s;
  logic [7:0]        mem_q [SIZE];

  // Address after one byte: page mode wraps within the page, sequential wraps the array.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [1:0] mode,
                                                  input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] inc;
    inc = a + ADDR_ONE;
    if (mode == MODE_PAGE) begin
      return (a & ~PAGE_MASK) | (inc & PAGE_MASK);
    end else begin
      return inc;
    end
  endfunction

  assign opcode_s = {instr_q[3:0], i_sqi_sio};

  // Next-state logic: command sequencing, address shifting and write strobes.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    nib_d       = nib_q;
    mode_d      = mode_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = {nib_q, i_sqi_sio};
    if (i_sqi_cs) begin
      // Deselect aborts everything in flight; mode and memory survive.
      state_d = ST_INSTR_0;
      instr_d = 8'h00;
      cnt_d   = 8'd0;
      nib_d   = 4'h0;
    end else begin
      case (state_q)
        ST_INSTR_0: begin
          instr_d = opcode_s;
          state_d = ST_INSTR_1;
        end
        ST_INSTR_1: begin
          instr_d = opcode_s;
          cnt_d   = 8'd0;
          case (opcode_s)
            OP_READ, OP_WRITE: state_d = ST_ADDR;
            OP_RDMR, OP_WRMR:  state_d = ST_DATA_0;
            default:           state_d = ST_IGNORE;
          endcase
        end
        ST_ADDR: begin
          addr_d = ADDR_W'({addr_q, i_sqi_sio});
          if (cnt_q == ADDR_LAST) begin
            cnt_d = 8'd0;
            if ((instr_q == OP_READ) && (DUMMY_CYCLES != 0)) begin
              state_d = ST_DUMMY;
            end else begin
              state_d = ST_DATA_0;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_DUMMY: begin
          if (cnt_q == DUMMY_LAST) begin
            cnt_d   = 8'd0;
            state_d = ST_DATA_0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_DATA_0: begin
          nib_d   = i_sqi_sio;
          state_d = ST_DATA_1;
        end
        ST_DATA_1: begin
          case (instr_q)
            OP_READ, OP_WRITE: begin
              mem_we_s = (instr_q == OP_WRITE);
              // Byte mode and the reserved encoding stop after one byte.
              if ((mode_q == MODE_SEQ) || (mode_q == MODE_PAGE)) begin
                addr_d  = next_addr(mode_q, addr_q);
                state_d = ST_DATA_0;
              end else begin
                state_d = ST_IGNORE;
              end
            end
            OP_RDMR: state_d = ST_DATA_0;
            OP_WRMR: begin
              mode_d  = nib_q[3:2];
              state_d = ST_IGNORE;
            end
            default: state_d = ST_IGNORE;
          endcase
        end
        ST_IGNORE: state_d = ST_IGNORE;
        default:   state_d = ST_INSTR_0;
      endcase
    end
  end

  // Output drive: only the data phases of READ/RDMR turn the bus around.
  always_comb begin
    if (instr_q == OP_RDMR) begin
      rd_byte_s = {mode_q, 6'b000000};
    end else begin
      rd_byte_s = mem_q[addr_q];
    end
    if (!i_sqi_cs && ((state_q == ST_DATA_0) || (state_q == ST_DATA_1)) &&
        ((instr_q == OP_READ) || (instr_q == OP_RDMR))) begin
      o_sqi_oe = 1'b1;
      if (state_q == ST_DATA_0) begin
        o_sqi_sio = rd_byte_s[7:4];
      end else begin
        o_sqi_sio = rd_byte_s[3:0];
      end
    end else begin
      o_sqi_oe  = 1'b0;
      o_sqi_sio = 4'bxxxx;
    end
  end

  // Control state register with asynchronous reset; mode defaults to sequential.
  always_ff @(posedge i_sqi_sck or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_INSTR_0;
      instr_q <= 8'h00;
      addr_q  <= '0;
      cnt_q   <= 8'd0;
      nib_q   <= 4'h0;
      mode_q  <= MODE_SEQ;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      mode_q  <= mode_d;
    end
  end

  // Memory array write port; contents are intentionally not reset.
  always_ff @(posedge i_sqi_sck) begin
    if (mem_we_s) begin
      mem_q[addr_q] <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_idli_sqi_mem_v2_m.sv
// Directed self-checking bench for idli_sqi_mem_v2_m (default parameters).
module tb_idli_sqi_mem_v2_m;

  logic       sck = 1'b0;
  logic       rst;
  logic       cs;
  logic [3:0] sio_in;
  logic [3:0] sio_out;
  logic       oe;
  logic       oe_seen;
  int         n_tests = 0;
  int         n_fail  = 0;

  typedef struct {
    logic       cs;
    logic [3:0] sio;
    logic       exp_oe;
    logic [3:0] exp_sio;
  } vec_t;

  vec_t vecs[$];

  always #5 sck = ~sck;

  idli_sqi_mem_v2_m dut (
    .i_sqi_sck (sck),
    .i_rst     (rst),
    .i_sqi_cs  (cs),
    .i_sqi_sio (sio_in),
    .o_sqi_sio (sio_out),
    .o_sqi_oe  (oe)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, let one rising edge happen, sample just after it.
  task automatic step(input logic c, input logic [3:0] s);
    @(negedge sck);
    cs = c;
    sio_in = s;
    @(posedge sck);
    #1;
    oe_seen = oe_seen | oe;
  endtask

  task automatic cmd(input logic [7:0] op);
    step(1'b0, op[7:4]);
    step(1'b0, op[3:0]);
  endtask

  task automatic send_addr(input logic [15:0] a);
    step(1'b0, a[15:12]);
    step(1'b0, a[11:8]);
    step(1'b0, a[7:4]);
    step(1'b0, a[3:0]);
  endtask

  task automatic wbyte(input logic [7:0] b);
    step(1'b0, b[7:4]);
    step(1'b0, b[3:0]);
  endtask

  task automatic end_cmd();
    step(1'b1, 4'h0);
  endtask

  task automatic rd_byte(output logic [7:0] b, output logic ok);
    logic [3:0] hi;
    logic o1;
    hi = sio_out;
    o1 = oe;
    step(1'b0, 4'h0);
    b  = {hi, sio_out};
    ok = o1 & oe;
    step(1'b0, 4'h0);
  endtask

  task automatic write_mem(input logic [15:0] a, input int n, input logic [7:0] b0,
                           input logic [7:0] b1);
    cmd(8'h02);
    send_addr(a);
    wbyte(b0);
    if (n > 1) wbyte(b1);
    end_cmd();
  endtask

  task automatic read_chk(input string nm, input logic [15:0] a, input int n,
                          input logic [7:0] e0, input logic [7:0] e1);
    logic [7:0] b;
    logic ok;
    cmd(8'h03);
    send_addr(a);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    rd_byte(b, ok);
    chk({nm, "_b0"}, b, e0);
    chk({nm, "_oe0"}, {7'd0, ok}, 8'd1);
    if (n > 1) begin
      rd_byte(b, ok);
      chk({nm, "_b1"}, b, e1);
      chk({nm, "_oe1"}, {7'd0, ok}, 8'd1);
    end
    end_cmd();
  endtask

  task automatic rdmr_chk(input string nm, input int n, input logic [7:0] e);
    logic [7:0] b;
    logic ok;
    cmd(8'h05);
    for (int i = 0; i < n; i++) begin
      rd_byte(b, ok);
      chk({nm, "_mode"}, b, e);
      chk({nm, "_oe"}, {7'd0, ok}, 8'd1);
    end
    end_cmd();
  endtask

  task automatic wrmr(input logic [7:0] v);
    cmd(8'h01);
    wbyte(v);
    end_cmd();
  endtask

  function automatic void add(input logic c, input logic [3:0] s, input logic eo,
                              input logic [3:0] es);
    vecs.push_back('{cs: c, sio: s, exp_oe: eo, exp_sio: es});
  endfunction

  initial begin
    logic [7:0] b;
    logic ok;

    // WRITE 0x0010 <- A5,3C
    add(1'b0, 4'h0, 1'b0, 4'h0); add(1'b0, 4'h2, 1'b0, 4'h0);
    add(1'b0, 4'h0, 1'b0, 4'h0); add(1'b0, 4'h0, 1'b0, 4'h0);
    add(1'b0, 4'h1, 1'b0, 4'h0); add(1'b0, 4'h0, 1'b0, 4'h0);
    add(1'b0, 4'hA, 1'b0, 4'h0); add(1'b0, 4'h5, 1'b0, 4'h0);
    add(1'b0, 4'h3, 1'b0, 4'h0); add(1'b0, 4'hC, 1'b0, 4'h0);
    add(1'b1, 4'h0, 1'b0, 4'h0);
    // READ 0x0010: oe rises after the 8th edge
    add(1'b0, 4'h0, 1'b0, 4'h0); add(1'b0, 4'h3, 1'b0, 4'h0);
    add(1'b0, 4'h0, 1'b0, 4'h0); add(1'b0, 4'h0, 1'b0, 4'h0);
    add(1'b0, 4'h1, 1'b0, 4'h0); add(1'b0, 4'h0, 1'b0, 4'h0);
    add(1'b0, 4'h0, 1'b0, 4'h0); add(1'b0, 4'h0, 1'b1, 4'hA);
    add(1'b0, 4'h0, 1'b1, 4'h5); add(1'b0, 4'h0, 1'b1, 4'h3);
    add(1'b0, 4'h0, 1'b1, 4'hC); add(1'b1, 4'h0, 1'b0, 4'h0);
    // RDMR: default sequential mode reads 0x40
    add(1'b0, 4'h0, 1'b0, 4'h0); add(1'b0, 4'h5, 1'b1, 4'h4);
    add(1'b0, 4'h0, 1'b1, 4'h0); add(1'b0, 4'h0, 1'b1, 4'h4);
    add(1'b0, 4'h0, 1'b1, 4'h0); add(1'b1, 4'h0, 1'b0, 4'h0);

    oe_seen = 1'b0;
    rst = 1'b1;
    cs = 1'b1;
    sio_in = 4'h0;
    repeat (2) @(posedge sck);
    #1;
    chk("reset_oe", {7'd0, oe}, 8'd0);
    @(negedge sck);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].cs, vecs[i].sio);
      chk($sformatf("vec%0d_oe", i), {7'd0, oe}, {7'd0, vecs[i].exp_oe});
      if (vecs[i].exp_oe) chk($sformatf("vec%0d_sio", i), {4'h0, sio_out}, {4'h0, vecs[i].exp_sio});
    end

    // Sequential wrap at the top of memory
    write_mem(16'hFFFF, 2, 8'h11, 8'h22);
    read_chk("seq_wrap", 16'hFFFF, 2, 8'h11, 8'h22);
    read_chk("seq_wrap0", 16'h0000, 1, 8'h22, 8'h00);

    // Page mode
    write_mem(16'h0020, 1, 8'h5A, 8'h00);
    write_mem(16'h0101, 1, 8'hC3, 8'h00);
    wrmr(8'h80);
    write_mem(16'h001F, 2, 8'h77, 8'h88);
    read_chk("page_wrap", 16'h001F, 2, 8'h77, 8'h88);
    read_chk("page_next_untouched", 16'h0020, 1, 8'h5A, 8'h00);
    rdmr_chk("rdmr_page", 2, 8'h80);

    // Byte mode: one byte per command, no bus drive during writes
    wrmr(8'h00);
    oe_seen = 1'b0;
    write_mem(16'h0100, 2, 8'h99, 8'hEE);
    chk("byte_write_oe", {7'd0, oe_seen}, 8'd0);
    cmd(8'h03);
    send_addr(16'h0100);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    rd_byte(b, ok);
    chk("byte_rd", b, 8'h99);
    chk("byte_rd_stop_oe", {7'd0, oe}, 8'd0);
    end_cmd();
    read_chk("byte_next_untouched", 16'h0101, 1, 8'hC3, 8'h00);

    // Write cut short by CS rising at the low-nibble edge
    wrmr(8'h40);
    write_mem(16'h0200, 1, 8'h11, 8'h00);
    cmd(8'h02);
    send_addr(16'h0200);
    step(1'b0, 4'hF);
    step(1'b1, 4'hE);
    read_chk("cut_write", 16'h0200, 1, 8'h11, 8'h00);

    // Unknown opcode is ignored until deselect
    oe_seen = 1'b0;
    cmd(8'h9F);
    send_addr(16'h0200);
    wbyte(8'h66);
    wbyte(8'h77);
    chk("ignore_oe", {7'd0, oe_seen}, 8'd0);
    end_cmd();
    read_chk("ignore_nowrite", 16'h0200, 1, 8'h11, 8'h00);

    // Partial WRMR leaves the mode alone
    wrmr(8'h80);
    cmd(8'h01);
    step(1'b0, 4'h4);
    end_cmd();
    rdmr_chk("partial_wrmr", 1, 8'h80);

    // Asynchronous reset mid-READ between SCK edges
    cmd(8'h03);
    send_addr(16'h0010);
    step(1'b0, 4'h0);
    step(1'b0, 4'h0);
    chk("pre_rst_oe", {7'd0, oe}, 8'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_oe_drop", {7'd0, oe}, 8'd0);
    rst = 1'b0;
    end_cmd();
    rdmr_chk("post_rst_mode", 1, 8'h40);
    read_chk("post_rst_mem", 16'h0010, 2, 8'hA5, 8'h3C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
